// File: rtl/avl_pio_ext_if.sv
// rtl/avl_pio_ext_if.sv - Avalon-MM register bus bundle for the PIO block
interface avl_pio_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avl_pio_ext.sv
// rtl/avl_pio_ext.sv - Parallel I/O port with edge capture and level interrupt
module avl_pio_ext #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  avl_pio_ext_if.slave       bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic [WIDTH-1:0]   out_port,
  output logic [WIDTH-1:0]   oe,
  output logic               irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_det;
  logic [31:0]      rdata;
  logic             unused_wdata;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];

  // Upper write data bits beyond WIDTH carry no meaning for this port.
  assign unused_wdata = ^bus.writedata;

  // Per-bit edge detection on the synchronised input, edge kind fixed at build time.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = sync2_q & ~prev_q;
      1:       edge_det = ~sync2_q & prev_q;
      default: edge_det = sync2_q ^ prev_q;
    endcase
  end

  // Next-state for bus-written registers, synchroniser chain and sticky capture.
  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    mask_d   = mask_q;
    edge_clr = '0;
    if (wr_en) begin
      case (bus.address)
        3'd0:    out_d    = wdata;
        3'd1:    dir_d    = wdata;
        3'd2:    mask_d   = wdata;
        3'd3:    edge_clr = wdata;
        3'd4:    out_d    = out_q | wdata;
        3'd5:    out_d    = out_q & ~wdata;
        default: ;
      endcase
    end
    // A fresh edge in the same cycle as its clear keeps the bit set.
    edge_d  = (edge_q & ~edge_clr) | edge_det;
    sync1_d = in_port;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // State registers; reset is asynchronous assert, released on clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= RESET_VALUE[WIDTH-1:0];
      dir_q   <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Zero-latency read mux; OUTSET/OUTCLEAR and reserved words read as zero.
  always_comb begin
    rdata = '0;
    case (bus.address)
      3'd0:    rdata[WIDTH-1:0] = sync2_q;
      3'd1:    rdata[WIDTH-1:0] = dir_q;
      3'd2:    rdata[WIDTH-1:0] = mask_q;
      3'd3:    rdata[WIDTH-1:0] = edge_q;
      default: rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;
  assign oe           = dir_q;
  assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_avl_pio_ext.sv
// tb/tb_avl_pio_ext.sv - Directed self-checking bench for avl_pio_ext
module tb_avl_pio_ext;

  localparam logic [7:0] RV0 = 8'h5A;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_port0, in_port2;
  logic [7:0] out_port0, out_port2;
  logic [7:0] oe0, oe2;
  logic       irq0, irq2;

  int n_cmp;
  int n_err;

  avl_pio_ext_if if0 ();
  avl_pio_ext_if if2 ();

  avl_pio_ext #(.WIDTH(8), .RESET_VALUE(32'(RV0)), .EDGE_TYPE(0)) u_dut0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (if0),
    .in_port  (in_port0),
    .out_port (out_port0),
    .oe       (oe0),
    .irq      (irq0)
  );

  avl_pio_ext #(.WIDTH(8), .RESET_VALUE(32'h0), .EDGE_TYPE(2)) u_dut2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (if2),
    .in_port  (in_port2),
    .out_port (out_port2),
    .oe       (oe2),
    .irq      (irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Single-cycle write, returns at the negedge after the capturing posedge.
  task automatic bus_wr(input bit which, input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    if (which) begin
      if2.address = addr; if2.writedata = data; if2.chipselect = 1'b1; if2.write_n = 1'b0;
    end else begin
      if0.address = addr; if0.writedata = data; if0.chipselect = 1'b1; if0.write_n = 1'b0;
    end
    @(negedge clk);
    if0.chipselect = 1'b0; if0.write_n = 1'b1;
    if2.chipselect = 1'b0; if2.write_n = 1'b1;
  endtask

  task automatic bus_rd(input bit which, input logic [2:0] addr, output logic [31:0] data);
    if (which) begin
      if2.address = addr; #1; data = if2.readdata;
    end else begin
      if0.address = addr; #1; data = if0.readdata;
    end
  endtask

  logic [31:0] rd;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n  = 1'b0;
    in_port0 = '0;
    in_port2 = '0;
    if0.address = '0; if0.chipselect = 1'b0; if0.write_n = 1'b1; if0.writedata = '0;
    if2.address = '0; if2.chipselect = 1'b0; if2.write_n = 1'b1; if2.writedata = '0;

    // Reset state
    wait_cycles(3);
    check("rst_out0", 32'(out_port0), 32'h5A);
    check("rst_oe0",  32'(oe0),       32'h00);
    check("rst_irq0", 32'(irq0),      32'h0);
    check("rst_out2", 32'(out_port2), 32'h00);
    reset_n = 1'b1;
    wait_cycles(2);

    // DATA / OUTSET / OUTCLEAR
    bus_wr(0, 3'd0, 32'hFFFF_FFA5);
    check("data_wr",  32'(out_port0), 32'hA5);
    bus_wr(0, 3'd4, 32'h0000_000A);
    check("outset",   32'(out_port0), 32'hAF);
    bus_wr(0, 3'd5, 32'h0000_0081);
    check("outclear", 32'(out_port0), 32'h2E);
    bus_rd(0, 3'd4, rd); check("rd_outset",   rd, 32'h0);
    bus_rd(0, 3'd5, rd); check("rd_outclear", rd, 32'h0);

    // DIRECTION and reserved addresses
    bus_wr(0, 3'd1, 32'h0000_00F0);
    check("oe_dir", 32'(oe0), 32'hF0);
    bus_rd(0, 3'd1, rd); check("rd_dir", rd, 32'h0000_00F0);
    bus_wr(0, 3'd6, 32'h1234_5678);
    bus_rd(0, 3'd6, rd); check("rd_rsv6", rd, 32'h0);
    bus_rd(0, 3'd7, rd); check("rd_rsv7", rd, 32'h0);
    check("rsv_noeff_out", 32'(out_port0), 32'h2E);
    check("rsv_noeff_oe",  32'(oe0),       32'hF0);

    // Rising-edge capture latency and irq
    bus_wr(0, 3'd2, 32'h0000_0001);
    bus_rd(0, 3'd2, rd); check("rd_mask", rd, 32'h01);
    in_port0 = 8'h01;                       // settles before edge N
    @(negedge clk);                         // after N
    bus_rd(0, 3'd0, rd); check("data_after_n", rd, 32'h00);
    @(negedge clk);                         // after N+1
    bus_rd(0, 3'd0, rd); check("data_after_n1", rd, 32'h01);
    bus_rd(0, 3'd3, rd); check("cap_after_n1",  rd, 32'h00);
    check("irq_after_n1", 32'(irq0), 32'h0);
    @(negedge clk);                         // after N+2
    bus_rd(0, 3'd3, rd); check("cap_after_n2", rd, 32'h01);
    check("irq_after_n2", 32'(irq0), 32'h1);
    bus_wr(0, 3'd3, 32'h0000_0000);
    bus_rd(0, 3'd3, rd); check("cap_wr0_keeps", rd, 32'h01);
    bus_wr(0, 3'd3, 32'h0000_0001);
    check("irq_cleared", 32'(irq0), 32'h0);
    bus_rd(0, 3'd3, rd); check("cap_cleared", rd, 32'h00);

    // Falling edge ignored by a rising-edge build
    in_port0 = 8'h00;
    wait_cycles(4);
    bus_rd(0, 3'd3, rd); check("fall_ignored", rd, 32'h00);

    // Edge detected in the same cycle as its write-1-clear: set wins
    in_port0 = 8'h01;                       // before edge N
    @(negedge clk);                         // after N
    @(negedge clk);                         // after N+1
    if0.address = 3'd3; if0.writedata = 32'h1; if0.chipselect = 1'b1; if0.write_n = 1'b0;
    @(negedge clk);                         // after N+2, clear and set coincide
    if0.chipselect = 1'b0; if0.write_n = 1'b1;
    bus_rd(0, 3'd3, rd); check("set_wins_cap", rd, 32'h01);
    check("set_wins_irq", 32'(irq0), 32'h1);
    @(negedge clk);
    check("set_wins_hold", 32'(irq0), 32'h1);
    bus_wr(0, 3'd3, 32'h0000_0001);
    check("set_wins_clr", 32'(irq0), 32'h0);

    // Any-edge build: two toggles captured, masked until mask set
    in_port2 = 8'h08;
    wait_cycles(3);
    in_port2 = 8'h00;
    wait_cycles(3);
    bus_rd(1, 3'd3, rd); check("any_cap", rd, 32'h08);
    check("any_irq_masked", 32'(irq2), 32'h0);
    bus_wr(1, 3'd2, 32'h0000_0008);
    check("any_irq_unmasked", 32'(irq2), 32'h1);
    bus_rd(1, 3'd0, rd); check("any_data", rd, 32'h00);

    // Asynchronous reset mid-operation
    in_port0 = 8'h03;
    wait_cycles(3);
    bus_wr(0, 3'd2, 32'h0000_0002);
    check("pre_rst_irq", 32'(irq0), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out", 32'(out_port0), 32'h5A);
    check("arst_oe",  32'(oe0),       32'h00);
    check("arst_irq", 32'(irq0),      32'h0);
    check("arst_irq2", 32'(irq2),     32'h0);
    in_port0 = 8'h00;
    in_port2 = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(4);
    bus_rd(0, 3'd3, rd); check("post_rst_cap", rd, 32'h00);
    bus_rd(0, 3'd0, rd); check("post_rst_data", rd, 32'h00);
    bus_rd(0, 3'd2, rd); check("post_rst_mask", rd, 32'h00);
    bus_rd(1, 3'd3, rd); check("post_rst_cap2", rd, 32'h00);
    check("post_rst_irq", 32'(irq0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avl_pio_ext.md
AVL_PIO_EXT -- requirements
Module: avl_pio_ext

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of port bits (legal 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, giving the reset value of the output data register (WIDTH bits).
REQ-003 The block SHALL have parameter EDGE_TYPE, default 0, selecting the capture edge: 0 rising, 1 falling, 2 any.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data; only bits [WIDTH-1:0] SHALL be used.
REQ-010 readdata  output  32  read data; bits [31:WIDTH] SHALL be 0.
REQ-011 in_port  input  WIDTH  asynchronous external inputs.
REQ-012 out_port  output  WIDTH  output data register value.
REQ-013 oe  output  WIDTH  per-bit output enable; equals the direction register.
REQ-014 irq  output  1  level interrupt, active-high.

Function
REQ-015 Register map (word address): 0 DATA, 1 DIRECTION, 2 IRQ_MASK, 3 EDGE_CAPTURE, 4 OUTSET, 5 OUTCLEAR, 6-7 reserved.
REQ-016 A write SHALL occur on a rising clk edge when chipselect=1 and write_n=0; otherwise no register changes from the bus.
REQ-017 Reads SHALL be zero-wait, zero-latency: readdata is a combinational function of address and current register state, independent of chipselect.
REQ-018 DATA write SHALL load out_reg <= writedata[WIDTH-1:0]; DATA read SHALL return the synchronised input value sync2.
REQ-019 OUTSET write SHALL do out_reg <= out_reg | writedata; OUTCLEAR write SHALL do out_reg <= out_reg & ~writedata; both SHALL read as 0.
REQ-020 DIRECTION and IRQ_MASK SHALL be plain read/write registers; bit=1 in DIRECTION drives oe high.
REQ-021 Reserved addresses SHALL read 0 and ignore writes.
REQ-022 in_port SHALL pass through a 2-flop synchroniser (sync1, sync2), then a third flop prev; no combinational path from in_port to any output.
REQ-023 Edge detect per bit: rising = sync2 & ~prev; falling = ~sync2 & prev; any = sync2 ^ prev; chosen by EDGE_TYPE.
REQ-024 An input change settling before edge N SHALL appear in DATA reads after edge N+1 and set EDGE_CAPTURE on edge N+2.
REQ-025 EDGE_CAPTURE bits SHALL be sticky; writing 1 to a bit clears it; writing 0 leaves it unchanged.
REQ-026 Simultaneous detected edge and write-1-clear on the same bit SHALL leave the bit set (set wins).
REQ-027 irq SHALL equal |(EDGE_CAPTURE & IRQ_MASK), combinational from registers only.
REQ-028 Capture SHALL operate regardless of DIRECTION and IRQ_MASK values.

Reset
REQ-029 While reset_n=0: out_reg=RESET_VALUE, DIRECTION=0, IRQ_MASK=0, EDGE_CAPTURE=0, sync1/sync2/prev=0; hence out_port=RESET_VALUE, oe=0, irq=0.
REQ-030 Reset asserted mid-operation SHALL clear state immediately (asynchronously); release SHALL be used synchronously by clk; no spurious capture SHALL result from the first post-reset sample if in_port=0.

Verification
REQ-031 WIDTH=8, write DATA=0xA5, then OUTSET 0x0A, then OUTCLEAR 0x81 -> out_port 0xA5, 0xAF, 0x2E on successive post-write cycles; reads of addr 4/5 return 0.
REQ-032 Write DIRECTION=0xF0 -> oe=0xF0 next cycle; read addr 1 returns 0x000000F0; write addr 6 then read -> 0.
REQ-033 EDGE_TYPE=0, IRQ_MASK=0x01, in_port bit0 0->1 before edge N -> DATA read bit0=1 after N+1, EDGE_CAPTURE=0x01 and irq=1 after N+2; write 0x01 to addr 3 -> irq=0.
REQ-034 Same setup, edge on bit0 detected in the same cycle as a write-1-clear of bit0 -> bit0 remains 1, irq stays 1.
REQ-035 EDGE_TYPE=2, toggle in_port bit3 twice with mask 0 -> EDGE_CAPTURE=0x08, irq=0; set mask 0x08 -> irq=1.
REQ-036 Drive state non-zero, assert reset_n=0 between clk edges -> out_port=RESET_VALUE, oe=0, irq=0 before the next clk edge.
